// File: rtl/serial_deserializer_pkg.sv
// Shared constants for the serial link: state encoding, default word width
// and the bit-counter width helper used by the deserializer.
package serial_deserializer_pkg;

    // Must match the upstream parallel-load shifter width.
    localparam int DEF_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter covers 0..WIDTH-1; floor of one bit keeps WIDTH=2 legal.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / word-out bundle of the deserializer; slave is the deserializer side,
// master is the link driver plus word consumer.
interface serial_deserializer_if
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             bit_en;
    logic             serial_in;
    logic             out_ready;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport slave (
        input  start, bit_en, serial_in, out_ready, clr_err,
        output data_out, out_valid, busy, overrun
    );

    modport master (
        output start, bit_en, serial_in, out_ready, clr_err,
        input  data_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// Rebuilds MSB-first framed serial bits into WIDTH-bit words on a one-entry valid/ready register.
// Word visible one cycle after its last bit; a word completing while the register is full and not taken is dropped and flags overrun.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_deserializer_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             ovr;
    logic [WIDTH-1:0] word;

    assign word          = {shreg[WIDTH-2:0], bus.serial_in};
    assign bus.data_out  = dout;
    assign bus.out_valid = valid;
    assign bus.busy      = (state == SHIFT);
    assign bus.overrun   = ovr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            dout  <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (valid && bus.out_ready) begin
                valid <= 1'b0;
            end
            if (bus.clr_err) begin
                ovr <= 1'b0;
            end

            // The upstream emits its first bit the cycle after load, so any
            // bit_en coinciding with start is stale and is discarded.
            if (bus.start) begin
                state <= SHIFT;
                cnt   <= '0;
                shreg <= '0;
            end else if (state == SHIFT && bus.bit_en) begin
                shreg <= word;
                if (cnt == LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                    // Loads cover both an empty register and a same-edge consume.
                    if (!valid || bus.out_ready) begin
                        dout  <= word;
                        valid <= 1'b1;
                    end else begin
                        ovr <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: framing, gaps, overrun, restart, reset and back-to-back words.
module tb_serial_deserializer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_deserializer_if #(.WIDTH(W)) bus ();

    serial_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sends the top n bits of w, MSB first, with gap idle cycles after each bit.
    task automatic send_bits(input logic [31:0] w, input int n, input int gap);
        logic [31:0] sh;
        sh = w;
        for (int i = 0; i < n; i++) begin
            bus.bit_en    = 1'b1;
            bus.serial_in = sh[31];
            sh            = sh << 1;
            tick();
            bus.bit_en    = 1'b0;
            bus.serial_in = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    logic [31:0] lb_words [4];

    initial begin
        bus.start     = 1'b0;
        bus.bit_en    = 1'b0;
        bus.serial_in = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_err   = 1'b0;
        lb_words[0] = 32'h0000_0000;
        lb_words[1] = 32'hFFFF_FFFF;
        lb_words[2] = 32'h8000_0001;
        lb_words[3] = 32'h1357_9BDF;

        // Reset state
        tick();
        tick();
        check("rst_data", bus.data_out, 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ovr", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;

        // bit_en in IDLE is ignored
        send_bits(32'hFFFF_FFFF, 32, 0);
        check("idle_ignore_valid", 32'(bus.out_valid), 32'h0);

        // Basic word
        bus.out_ready = 1'b1;
        bus.bit_en    = 1'b1;
        bus.serial_in = 1'b1;
        pulse_start();
        bus.bit_en    = 1'b0;
        check("basic_busy_start", 32'(bus.busy), 32'h1);
        send_bits(32'hA5A5_1234, 31, 0);
        check("basic_busy_mid", 32'(bus.busy), 32'h1);
        check("basic_valid_early", 32'(bus.out_valid), 32'h0);
        send_bits(32'hA5A5_1234 << 31, 1, 0);
        check("basic_data", bus.data_out, 32'hA5A5_1234);
        check("basic_valid", 32'(bus.out_valid), 32'h1);
        check("basic_busy_end", 32'(bus.busy), 32'h0);
        tick();
        check("basic_valid_drop", 32'(bus.out_valid), 32'h0);
        check("basic_data_hold", bus.data_out, 32'hA5A5_1234);

        // Gapped bits
        pulse_start();
        send_bits(32'hDEAD_BEEF, 31, 2);
        check("gap_busy", 32'(bus.busy), 32'h1);
        check("gap_valid_early", 32'(bus.out_valid), 32'h0);
        send_bits(32'hDEAD_BEEF << 31, 1, 0);
        check("gap_data", bus.data_out, 32'hDEAD_BEEF);
        check("gap_valid", 32'(bus.out_valid), 32'h1);
        tick();

        // Overrun; clr_err on the setting edge loses
        bus.out_ready = 1'b0;
        pulse_start();
        send_bits(32'h0000_0001, 32, 0);
        check("ovr_first_data", bus.data_out, 32'h0000_0001);
        pulse_start();
        send_bits(32'hFFFF_FFFF, 31, 0);
        bus.clr_err = 1'b1;
        send_bits(32'h8000_0000, 1, 0);
        bus.clr_err = 1'b0;
        check("ovr_data_kept", bus.data_out, 32'h0000_0001);
        check("ovr_valid", 32'(bus.out_valid), 32'h1);
        check("ovr_flag", 32'(bus.overrun), 32'h1);
        tick();
        check("ovr_sticky", 32'(bus.overrun), 32'h1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("ovr_cleared", 32'(bus.overrun), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check("ovr_consumed", 32'(bus.out_valid), 32'h0);

        // Restart mid-frame
        pulse_start();
        send_bits(32'hFFC0_0000, 10, 0);
        pulse_start();
        send_bits(32'h1234_5678, 32, 0);
        check("restart_data", bus.data_out, 32'h1234_5678);
        check("restart_ovr", 32'(bus.overrun), 32'h0);
        tick();

        // Completion on the same edge the held word is consumed
        bus.out_ready = 1'b0;
        pulse_start();
        send_bits(32'h0000_AAAA, 32, 0);
        check("coin_first", bus.data_out, 32'h0000_AAAA);
        pulse_start();
        send_bits(32'h5555_FFFF, 31, 0);
        check("coin_hold", bus.data_out, 32'h0000_AAAA);
        bus.out_ready = 1'b1;
        send_bits(32'h5555_FFFF << 31, 1, 0);
        check("coin_valid", 32'(bus.out_valid), 32'h1);
        check("coin_data", bus.data_out, 32'h5555_FFFF);
        check("coin_ovr", 32'(bus.overrun), 32'h0);
        tick();
        check("coin_drop", 32'(bus.out_valid), 32'h0);

        // Reset at bit 20
        pulse_start();
        send_bits(32'hFFFF_FFFF, 20, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_data", bus.data_out, 32'h0);
        check("mrst_valid", 32'(bus.out_valid), 32'h0);
        check("mrst_busy", 32'(bus.busy), 32'h0);
        send_bits(32'hFFFF_FFFF, 32, 0);
        check("mrst_noword", 32'(bus.out_valid), 32'h0);
        check("mrst_data2", bus.data_out, 32'h0);

        // Back-to-back words; each start coincides with consuming the previous word
        for (int k = 0; k < 4; k++) begin
            pulse_start();
            send_bits(lb_words[k], 32, 0);
            check("lb_valid", 32'(bus.out_valid), 32'h1);
            check("lb_data", bus.data_out, lb_words[k]);
        end
        tick();
        check("lb_drain", 32'(bus.out_valid), 32'h0);
        check("lb_ovr", 32'(bus.overrun), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Downstream partner of the team's 32-bit parallel-load, MSB-first serial shifter.
- Collects a framed serial bit stream back into a WIDTH-bit word, MSB first.
- Presents each complete word on a one-entry valid/ready output register.
- Flags overrun when a new word completes while the previous one is still unconsumed.
- Sits between the serial link (shifter output) and the word-level consumer.

Parameters:
- WIDTH, 32, word length in bits; must match the upstream shifter width (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  frame start; mirrors the upstream load pulse.
- bit_en  input  1  serial_in carries a valid bit this cycle.
- serial_in  input  1  serial data, MSB of word first.
- out_ready  input  1  consumer accepts data_out this cycle.
- clr_err  input  1  clears the sticky overrun flag.
- data_out  output  WIDTH  assembled word.
- out_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a frame is in progress (state SHIFT).
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Clock and reset: one clock (clk). rst_n is sampled only at the clk rising edge, active-low. Reset has priority over all other inputs.
- Reset values: state=IDLE, bit count=0, shift register=0, data_out=0, out_valid=0, busy=0, overrun=0. A reset mid-frame discards the partial word.
- States:
  - IDLE: waits for start. bit_en is ignored.
  - SHIFT: accumulates bits.
  - busy = (state==SHIFT), registered.
- IDLE→SHIFT on start. Count is cleared. Any bit_en in the same cycle is discarded, because the upstream emits its first bit the cycle after load.
- start while in SHIFT restarts the frame: partial word discarded, count=0, stay in SHIFT, bit_en that cycle discarded, no error raised.
- Each bit in SHIFT (bit_en=1, start=0): shreg <= {shreg[WIDTH-2:0], serial_in}; count <= count+1.
- Word completion (bit_en with count==WIDTH-1):
  - Completed word = {shreg[WIDTH-2:0], serial_in}.
  - State→IDLE, count=0.
  - Latency: word is visible on data_out with out_valid=1 on the cycle after the edge that sampled the last bit.
- Output handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1.
  - out_valid then falls, unless a new word loads on the same edge.
  - data_out is held stable while out_valid=1 and no transfer occurs.
- Completion collisions:
  - out_valid=0: word loads normally.
  - out_valid=1 and out_ready=1: old word consumed, new word loads, out_valid stays 1.
  - out_valid=1 and out_ready=0: new word dropped, data_out unchanged, overrun<=1.
- overrun is sticky. It is cleared by clr_err or reset. If set and clear occur on the same edge, set wins.
- Bit counter width is clog2(WIDTH). It never wraps beyond WIDTH-1.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=1'b0, SHIFT=1'b1.
  - Default word width constant: 32, shared with the upstream shifter.
  - Counter-width function/constant: clog2(WIDTH).
- Single module, no sub-module required. The output holding register stays inline; it is too small to justify splitting out.

Test Plan:
- Basic word: reset; start; 32 consecutive bit_en carrying 0xA5A51234 MSB first; out_ready=1 → data_out=0xA5A51234 and out_valid=1 exactly one cycle after the 32nd bit edge; out_valid=0 the next cycle; busy=1 only during bits.
- Gapped bits: same frame with 0xDEADBEEF, bit_en every third cycle → data_out=0xDEADBEEF; busy stays 1 through the gaps; count is not advanced on idle cycles.
- Overrun: out_ready=0; frame 0x00000001, then a second frame 0xFFFFFFFF → data_out stays 0x00000001, out_valid=1, overrun=1; pulse clr_err → overrun=0; raise out_ready → out_valid drops.
- Restart and coincident consume:
  - After 10 bits, pulse start, then send 0x12345678 → data_out=0x12345678, with no trace of the partial bits.
  - Hold word 0x0000AAAA unconsumed; complete 0x5555FFFF on the same edge out_ready=1 → out_valid stays 1, data_out=0x5555FFFF, overrun=0.
- Reset mid-frame: drive rst_n=0 for one edge at bit 20 → all outputs 0, state IDLE; subsequent bit_en without start produces no word.
- Back-to-back loopback: connect the upstream shifter output to serial_in; start aligned to load; 4 words (0x0, 0xFFFFFFFF, 0x80000001, 0x13579BDF) → all received in order, no overrun.
